// File: rtl/period_wave_gen_pkg.sv
// period_wave_gen shared types and constants.
// State encoding and default widths for the period generator.
package period_wave_gen_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int WIDTH_DEF   = 8;
    localparam int CYCLE_CNT_W = 16;

endpackage

// File: rtl/period_down_counter.sv
// Loadable down counter with terminal flag.
// Load places val-1 so the terminal edge closes a val-cycle interval.
module period_down_counter
    import period_wave_gen_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] cnt;

    // count register: clear beats load beats decrement
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val - ONE;
        end else if (dec) begin
            cnt <= cnt - ONE;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/period_wave_gen.sv
// Programmable period tick and square-wave generator.
// Optional PERIOD_WAVE_GEN_CYCLE_CNT_EN adds a 16-bit tick counter output.
module period_wave_gen
    import period_wave_gen_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [WIDTH-1:0]       set_period,
    output logic                   tick,
    output logic                   wave_out,
    output logic [WIDTH-1:0]       cur_period,
    output logic                   busy,
    output logic                   update_ack
`ifdef PERIOD_WAVE_GEN_CYCLE_CNT_EN
    ,
    output logic [CYCLE_CNT_W-1:0] period_count
`endif
);

    state_t state;
    state_t state_n;
    logic   zero;
    logic   load;
    logic   clear;
    logic   dec;
    logic   tick_n;
    logic   wave_n;
    logic   ack_n;
    logic   sp_nz;

    assign sp_nz = (set_period != '0);

    period_down_counter #(
        .WIDTH(WIDTH)
    ) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear),
        .load    (load),
        .load_val(set_period),
        .dec     (dec),
        .zero    (zero)
    );

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // next state and counter control; abort on en=0 pre-empts a terminal tick
    always_comb begin
        state_n = state;
        load    = 1'b0;
        clear   = 1'b0;
        dec     = 1'b0;
        tick_n  = 1'b0;
        wave_n  = wave_out;
        unique case (state)
            IDLE: begin
                wave_n = 1'b0;
                if (en && sp_nz) begin
                    state_n = RUN;
                    load    = 1'b1;
                end
            end
            RUN: begin
                if (!en) begin
                    state_n = IDLE;
                    clear   = 1'b1;
                    wave_n  = 1'b0;
                end else if (!zero) begin
                    dec = 1'b1;
                end else begin
                    tick_n = 1'b1;
                    wave_n = ~wave_out;
                    if (sp_nz) load = 1'b1;
                    else       state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        ack_n = load && (set_period != cur_period);
    end

    // registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            tick       <= 1'b0;
            wave_out   <= 1'b0;
            busy       <= 1'b0;
            update_ack <= 1'b0;
            cur_period <= '0;
        end else begin
            tick       <= tick_n;
            wave_out   <= wave_n;
            busy       <= (state_n == RUN);
            update_ack <= ack_n;
            if (load) cur_period <= set_period;
        end
    end

`ifdef PERIOD_WAVE_GEN_CYCLE_CNT_EN
    // tick tally, cleared only by reset, wraps naturally
    always_ff @(posedge clk) begin
        if (rst)         period_count <= '0;
        else if (tick_n) period_count <= period_count + 1'b1;
    end
`endif

endmodule
